// File: rtl/tm_lif_pkg.sv
// Shared constants and arithmetic helpers for the time-multiplexed LIF neuron array.
package tm_lif_pkg;

  localparam int RST_ZERO = 0;
  localparam int RST_SUB  = 1;
  localparam int SAT_W    = 8;

  // Unsigned add clamped to the largest w-bit value (w at most 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w = SAT_W);
    logic [32:0] sum;
    logic [32:0] maxVal;
    sum    = {1'b0, a} + {1'b0, b};
    maxVal = (33'd1 << w) - 33'd1;
    return 32'((sum > maxVal) ? maxVal : sum);
  endfunction

endpackage

// File: rtl/tm_lif_array_core.sv
// Combinational single-neuron update: leak, saturating integrate, threshold compare, post-spike reset.
module lif_update_core
  import tm_lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int RESET_MODE = RST_ZERO
) (
  input  logic [W-1:0] i_state,
  input  logic [W-1:0] i_current,
  input  logic [W-1:0] i_thresh,
  input  logic         i_refr_nonzero,
  output logic [W-1:0] o_next_state,
  output logic         o_spike
);

  logic [W-1:0] w_leaked;
  logic [W-1:0] w_sum;

  assign w_leaked = i_state >> LEAK_SHIFT;
  assign w_sum    = W'(sat_add(32'(w_leaked), 32'(i_current), W));

  // A refractory neuron is forced silent and discharged, whatever current arrives.
  always_comb begin
    o_next_state = w_sum;
    o_spike      = 1'b0;
    if (i_refr_nonzero) begin
      o_next_state = '0;
    end else if (w_sum >= i_thresh) begin
      o_spike      = 1'b1;
      o_next_state = (RESET_MODE == RST_SUB) ? (w_sum - i_thresh) : '0;
    end
  end

endmodule

// File: rtl/tm_lif_array.sv
// Time-multiplexed LIF neuron array: one shared update core sweeps all neurons, framing a spike vector per sweep.
module tm_lif_array
  import tm_lif_pkg::*;
#(
  parameter int N_NEURONS   = 8,
  parameter int W           = 8,
  parameter int LEAK_SHIFT  = 1,
  parameter int THRESH_INIT = 127,
  parameter int REFRACT     = 2,
  parameter int RESET_MODE  = 0,
  localparam int IW         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [W-1:0]         current_in,
  output logic [IW-1:0]        idx_out,
  input  logic                 thr_we,
  input  logic [IW-1:0]        thr_addr,
  input  logic [W-1:0]         thr_data,
  output logic [W-1:0]         state_out,
  output logic [IW-1:0]        state_idx,
  output logic [N_NEURONS-1:0] spike_out,
  output logic                 spike_valid
);

  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  logic [IW-1:0]        r_slot;
  logic [W-1:0]         r_state [N_NEURONS];
  logic [RW-1:0]        r_refr  [N_NEURONS];
  logic [W-1:0]         r_thr   [N_NEURONS];
  logic [N_NEURONS-1:0] r_acc;

  logic [W-1:0]         w_nextState;
  logic                 w_spike;
  logic                 w_refrNonzero;
  logic                 w_last;
  logic                 w_thrInRange;
  logic [N_NEURONS-1:0] w_accNext;

  assign idx_out       = r_slot;
  assign w_refrNonzero = (r_refr[r_slot] != '0);
  assign w_last        = (r_slot == IW'(N_NEURONS - 1));
  assign w_thrInRange  = ({1'b0, thr_addr} < (IW + 1)'(N_NEURONS));

  lif_update_core #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .RESET_MODE (RESET_MODE)
  ) u_core (
    .i_state        (r_state[r_slot]),
    .i_current      (current_in),
    .i_thresh       (r_thr[r_slot]),
    .i_refr_nonzero (w_refrNonzero),
    .o_next_state   (w_nextState),
    .o_spike        (w_spike)
  );

  always_comb begin
    w_accNext         = r_acc;
    w_accNext[r_slot] = w_spike;
  end

  // Threshold writes read-before-write: the core above already sees the old value this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot      <= '0;
      r_acc       <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      state_out   <= '0;
      state_idx   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i] <= '0;
        r_refr[i]  <= '0;
        r_thr[i]   <= W'(THRESH_INIT);
      end
    end else begin
      spike_valid <= 1'b0;
      if (en) begin
        r_state[r_slot] <= w_nextState;
        if (w_refrNonzero) begin
          r_refr[r_slot] <= r_refr[r_slot] - RW'(1);
        end else if (w_spike) begin
          r_refr[r_slot] <= RW'(REFRACT);
        end
        state_out <= w_nextState;
        state_idx <= r_slot;
        if (w_last) begin
          r_slot      <= '0;
          spike_out   <= w_accNext;
          r_acc       <= '0;
          spike_valid <= 1'b1;
        end else begin
          r_slot <= r_slot + IW'(1);
          r_acc  <= w_accNext;
        end
      end
      if (thr_we && w_thrInRange) begin
        r_thr[thr_addr] <= thr_data;
      end
    end
  end

endmodule

// File: doc/tm_lif_array.md
Name: tm_lif_array

Overview:
Parametrised time-multiplexed leaky integrate-and-fire neuron array. One shared update datapath serves N_NEURONS neurons, one neuron per enabled cycle, with membrane state held in a register array. It adds the following to the fixed 8x8-bit array:
- per-neuron programmable thresholds
- input saturation
- a refractory period
- a selectable post-spike reset mode
- a framed spike-vector output once per sweep

It sits between the input-current encoder and the spike consumer/readout logic.

Parameters:
N_NEURONS, 8, number of neurons in the array (≥2; need not be a power of 2)
W, 8, membrane state, current and threshold width in bits
LEAK_SHIFT, 1, leak implemented as state >> LEAK_SHIFT per sweep (0..W-1)
THRESH_INIT, 127, reset value of every threshold register
REFRACT, 2, sweeps a neuron stays silent after a spike (0 disables)
RESET_MODE, 0, post-spike action: 0 = state cleared to 0; 1 = state minus threshold

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  advance the time-multiplex slot and update the addressed neuron
current_in  in  W  input current for neuron idx_out, sampled this cycle
idx_out  out  IW=$clog2(N_NEURONS)  neuron addressed this cycle (registered slot counter)
thr_we  in  1  threshold write strobe
thr_addr  in  IW  threshold write address
thr_data  in  W  threshold write data
state_out  out  W  updated state of the neuron processed in the previous enabled cycle
state_idx  out  IW  index belonging to state_out
spike_out  out  N_NEURONS  spike vector of the last completed sweep, bit i = neuron i
spike_valid  out  1  one-cycle pulse: spike_out has just been updated

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. Single clock domain.
- Reset values:
  - slot counter 0 (so idx_out = 0)
  - all states 0, all refractory counters 0, all thresholds THRESH_INIT
  - spike_out 0, spike_valid 0, state_out 0, state_idx 0, internal spike accumulator 0
- A reset asserted mid-sweep discards the partial sweep. No spike_valid is produced for it.
- Neuron update, on a clock edge with en = 1, for i = idx_out:
  - leaked = state[i] >> LEAK_SHIFT
  - sum = leaked + current_in, computed at W+1 bits and saturated to 2^W-1
  - If refr[i] != 0: state[i] <= 0, refr[i] <= refr[i]-1, no spike. current_in is ignored.
  - Else if sum >= thr[i]: spike; refr[i] <= REFRACT. state[i] <= 0 (RESET_MODE 0) or sum - thr[i] (RESET_MODE 1).
  - Else: state[i] <= sum, no spike.
- Outputs after each enabled update:
  - state_out / state_idx register the new state and index of neuron i. Latency is 1 cycle after sampling.
  - The spike result goes into accumulator bit i.
- Sweep framing:
  - The slot counter counts 0..N_NEURONS-1 and wraps to 0.
  - On the enabled edge that processes slot N_NEURONS-1, spike_out <= accumulator including that neuron's result. The accumulator clears, and spike_valid = 1 for the following cycle only.
  - spike_out holds its value until the next sweep completes.
- Pause (en = 0):
  - The counter, states, refractory counters and accumulator all hold.
  - spike_valid = 0; state_out holds.
- Threshold write: thr[thr_addr] <= thr_data on any edge with thr_we, regardless of en.
  - If it targets the neuron being updated in the same cycle, the comparison uses the OLD threshold. The new value is stored for subsequent sweeps.
  - An out-of-range thr_addr (≥ N_NEURONS) is ignored.
- Threshold = 0 means the neuron spikes on every non-refractory update.

Decomposition:
- Package tm_lif_pkg holds:
  - the reset-mode constants RST_ZERO = 0 and RST_SUB = 1
  - a saturating-add function sat_add(a, b) parametrised on W via a localparam default
- Sub-module lif_update_core: a combinational single-neuron datapath. It takes state, current, threshold, refr_nonzero and produces next_state and spike. Instantiated once.
- The top level holds the counter, register arrays, threshold write port and framing.

Test Plan (defaults unless stated):
1. Reset, then current_in = 0 continuously with en = 1 → spike_valid pulses every 8 cycles, spike_out = 8'h00, all state_out = 0.
2. current_in = 64 for neuron 0, 0 for the others → neuron 0 state per sweep 64, 96, 112, 120, 124, 126, 127.
   - Sweep 7 spikes: spike_out = 8'h01, state goes to 0.
   - Sweeps 8–9 are refractory: state 0, bit 0 clear.
   - Sweep 10 integrates again to 64.
3. thr[3] = 200, RESET_MODE = 1, current 150 to neuron 3 → sweep 1 state 150. Sweep 2 sum 225 spikes, state 25. REFRACT = 0 build: sweep 3 gives 12 + 150 = 162.
4. Saturation: thr[5] = 255, current 200 → sweep 1 state 200. Sweep 2 sum 100 + 200 saturates to 255 and spikes (spike_out bit 5).
5. Drop en for 5 cycles at idx_out = 4 → idx_out stays 4, no spike_valid, state_out unchanged. After en returns, the sweep completes with identical results to an unpaused run.
6. Collision: thr_we at idx_out = 2 with thr_data = 10 while neuron 2 sum = 50 under thr = 127 → no spike this sweep; a spike next sweep. Also assert rst at idx_out = 6 → no spike_valid, idx_out = 0 and all states 0 next cycle.
